// File: rtl/ysyx_mem_arbiter_if.sv
// Handshake bundle for ysyx_mem_arbiter: IFU fetch port, LSU load/store port
// and the shared valid/ready physical-memory port.
interface ysyx_mem_arbiter_if #(
    parameter int AW = 32
);
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_resp_valid;
    logic [31:0]   ifu_rdata;

    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [1:0]    lsu_size;
    logic          lsu_sext;
    logic [31:0]   lsu_wdata;
    logic          lsu_resp_valid;
    logic [31:0]   lsu_rdata;
    logic          lsu_err;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_resp_valid;
    logic [31:0]   mem_rdata;

    // The arbiter side.
    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_size, lsu_sext, lsu_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    // The requesters plus memory, seen from outside the arbiter.
    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_size, lsu_sext, lsu_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// IFU/LSU arbiter and sequencer for the single shared memory port.
// Define ARB_RR_EN for round-robin arbitration; default is LSU-over-IFU priority.
module ysyx_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ysyx_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic          mem_req_valid_q, mem_req_valid_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_wen_q, mem_wen_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wmask_q, mem_wmask_d;
    logic          ifu_resp_valid_q, ifu_resp_valid_d;
    logic          lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DW-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DW-1:0] lsu_rdata_q, lsu_rdata_d;
    logic          lsu_err_q, lsu_err_d;

    logic          grant_lsu, grant_ifu, in_idle, lsu_fire, ifu_fire;
    logic          lsu_misaligned;
    logic [3:0]    st_wmask;
    logic [DW-1:0] st_wdata, shifted, load_data;
    logic          unused_ifu_addr;

    assign unused_ifu_addr = ^bus.ifu_addr[1:0];

`ifdef ARB_RR_EN
    owner_e last_grant_q, last_grant_d;
    assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || last_grant_q == OWN_IFU);
`else
    assign grant_lsu = bus.lsu_req_valid;
`endif
    assign grant_ifu = bus.ifu_req_valid && !grant_lsu;

    // Gating with rst_n keeps both readies low for the whole reset window.
    assign in_idle           = (state_q == IDLE) && rst_n;
    assign bus.lsu_req_ready = in_idle && grant_lsu;
    assign bus.ifu_req_ready = in_idle && grant_ifu;
    assign lsu_fire          = bus.lsu_req_valid && bus.lsu_req_ready;
    assign ifu_fire          = bus.ifu_req_valid && bus.ifu_req_ready;

    // Store lane formatting and the alignment check are decided at grant time.
    always_comb begin
        lsu_misaligned = 1'b1;
        st_wmask       = 4'b1111;
        st_wdata       = bus.lsu_wdata;
        case (bus.lsu_size)
            2'b00: begin
                lsu_misaligned = 1'b0;
                st_wmask       = 4'b0001 << bus.lsu_addr[1:0];
                st_wdata       = {4{bus.lsu_wdata[7:0]}};
            end
            2'b01: begin
                lsu_misaligned = bus.lsu_addr[0];
                st_wmask       = 4'b0011 << bus.lsu_addr[1:0];
                st_wdata       = {2{bus.lsu_wdata[15:0]}};
            end
            2'b10:   lsu_misaligned = |bus.lsu_addr[1:0];
            default: lsu_misaligned = 1'b1;
        endcase
    end

    assign shifted = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_data = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // NOTE: every _d takes its _q value first, so no path leaves a variable
    // unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        off_d            = off_q;
        size_d           = size_q;
        sext_d           = sext_q;
        mem_req_valid_d  = mem_req_valid_q;
        mem_addr_d       = mem_addr_q;
        mem_wen_d        = mem_wen_q;
        mem_wdata_d      = mem_wdata_q;
        mem_wmask_d      = mem_wmask_q;
        ifu_resp_valid_d = 1'b0;
        lsu_resp_valid_d = 1'b0;
        ifu_rdata_d      = ifu_rdata_q;
        lsu_rdata_d      = lsu_rdata_q;
        lsu_err_d        = lsu_err_q;
`ifdef ARB_RR_EN
        last_grant_d     = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (lsu_fire) begin
                    owner_d     = OWN_LSU;
                    off_d       = bus.lsu_addr[1:0];
                    size_d      = bus.lsu_size;
                    sext_d      = bus.lsu_sext;
                    mem_addr_d  = {bus.lsu_addr[AW-1:2], 2'b00};
                    mem_wen_d   = bus.lsu_wen;
                    mem_wmask_d = bus.lsu_wen ? st_wmask : 4'b0000;
                    mem_wdata_d = st_wdata;
`ifdef ARB_RR_EN
                    last_grant_d = OWN_LSU;
`endif
                    if (lsu_misaligned) begin
                        state_d          = RESP;
                        lsu_resp_valid_d = 1'b1;
                        lsu_err_d        = 1'b1;
                        lsu_rdata_d      = '0;
                    end else begin
                        state_d         = REQ;
                        mem_req_valid_d = 1'b1;
                    end
                end else if (ifu_fire) begin
                    owner_d         = OWN_IFU;
                    mem_addr_d      = {bus.ifu_addr[AW-1:2], 2'b00};
                    mem_wen_d       = 1'b0;
                    mem_wmask_d     = 4'b0000;
                    mem_wdata_d     = '0;
                    state_d         = REQ;
                    mem_req_valid_d = 1'b1;
`ifdef ARB_RR_EN
                    last_grant_d    = OWN_IFU;
`endif
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_d = RESP;
                    if (owner_q == OWN_LSU) begin
                        lsu_resp_valid_d = 1'b1;
                        lsu_err_d        = 1'b0;
                        lsu_rdata_d      = mem_wen_q ? '0 : load_data;
                    end else begin
                        ifu_resp_valid_d = 1'b1;
                        ifu_rdata_d      = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d   = IDLE;
                lsu_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            owner_q          <= OWN_IFU;
            off_q            <= '0;
            size_q           <= '0;
            sext_q           <= 1'b0;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
            lsu_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            off_q            <= off_d;
            size_q           <= size_d;
            sext_q           <= sext_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_wen_q        <= mem_wen_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_wmask_q      <= mem_wmask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            lsu_rdata_q      <= lsu_rdata_d;
            lsu_err_q        <= lsu_err_d;
        end
    end

`ifdef ARB_RR_EN
    // Reset to IFU so the LSU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= OWN_IFU;
        else        last_grant_q <= last_grant_d;
    end
`endif

    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wen        = mem_wen_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_wmask      = mem_wmask_q;
    assign bus.ifu_resp_valid = ifu_resp_valid_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_resp_valid = lsu_resp_valid_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign bus.lsu_err        = lsu_err_q;
endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Scoreboard bench for ysyx_mem_arbiter: drivers push expected responses and
// memory requests, a memory model and a response monitor pop and compare.
module tb_ysyx_mem_arbiter;
    localparam int AW = 32;

    typedef struct {
        bit          lsu;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       tag;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        bit          chk_mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rsp_dly;
        string       tag;
    } mreq_t;

    resp_t exp_q[$];
    mreq_t mem_q[$];
    bit    grant_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    bit    mem_auto = 1'b1;
    logic  clk = 1'b0;
    logic  rst_n = 1'b1;

    ysyx_mem_arbiter_if #(.AW(AW)) bus ();

    ysyx_mem_arbiter #(.AW(AW), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: checks each request against the bench's expectation.
    initial begin
        mreq_t e;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (mem_auto && bus.mem_req_valid) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", bus.mem_req_valid, 1'b0);
                end else begin
                    e = mem_q.pop_front();
                    check({e.tag, "_mem_addr"}, bus.mem_addr, e.addr);
                    check({e.tag, "_mem_wen"}, bus.mem_wen, e.wen);
                    if (e.chk_mask) check({e.tag, "_mem_wmask"}, bus.mem_wmask, e.wmask);
                    if (e.wen) check({e.tag, "_mem_wdata"}, bus.mem_wdata, e.wdata);
                    for (int i = 0; i < e.rdy_dly; i++) begin
                        @(negedge clk);
                        #1;
                        check({e.tag, "_stall_fields"},
                              {bus.mem_req_valid, bus.mem_wen, bus.mem_wmask, bus.mem_addr},
                              {1'b1, e.wen, bus.mem_wmask & {4{!e.chk_mask}} | (e.wmask & {4{e.chk_mask}}), e.addr});
                        check({e.tag, "_stall_ready"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
                    end
                    bus.mem_req_ready = 1'b1;
                    @(negedge clk);
                    bus.mem_req_ready = 1'b0;
                    check({e.tag, "_req_drop"}, bus.mem_req_valid, 1'b0);
                    repeat (e.rsp_dly) @(negedge clk);
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = e.rdata;
                    @(negedge clk);
                    bus.mem_resp_valid = 1'b0;
                    bus.mem_rdata      = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check({e.tag, "_owner"}, {bus.ifu_resp_valid, bus.lsu_resp_valid},
                          e.lsu ? 2'b01 : 2'b10);
                    check({e.tag, "_latency"}, cyc, e.cyc);
                    if (e.lsu) begin
                        check({e.tag, "_rdata"}, bus.lsu_rdata, e.rdata);
                        check({e.tag, "_err"}, bus.lsu_err, e.err);
                    end else begin
                        check({e.tag, "_rdata"}, bus.ifu_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic lsu_issue(input string tag, input logic [31:0] addr, input logic wen,
                             input logic [1:0] size, input logic sext, input logic [31:0] wdata,
                             input logic exp_err, input logic [31:0] exp_maddr,
                             input logic [3:0] exp_wmask, input logic [31:0] exp_wdata,
                             input logic [31:0] mrdata, input logic [31:0] exp_rdata,
                             input int rdy_dly, input int rsp_dly);
        resp_t r;
        mreq_t m;
        bit    ok = 1'b0;
        @(negedge clk);
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = addr;
        bus.lsu_wen       = wen;
        bus.lsu_size      = size;
        bus.lsu_sext      = sext;
        bus.lsu_wdata     = wdata;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.lsu_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check({tag, "_grant"}, bus.lsu_req_ready, 1'b1);
        end else begin
            grant_q.push_back(1'b1);
            r.lsu = 1'b1;
            r.tag = tag;
            r.err = exp_err;
            r.rdata = exp_err ? 32'h0 : exp_rdata;
            r.cyc = exp_err ? cyc + 1 : cyc + 3 + rdy_dly + rsp_dly;
            exp_q.push_back(r);
            if (!exp_err) begin
                m.addr = exp_maddr; m.wen = wen; m.wmask = exp_wmask; m.chk_mask = 1'b1;
                m.wdata = exp_wdata; m.rdata = mrdata; m.rdy_dly = rdy_dly;
                m.rsp_dly = rsp_dly; m.tag = tag;
                mem_q.push_back(m);
            end
        end
        @(posedge clk);
        #1;
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic lsu_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic sext, input logic [31:0] mrdata,
                            input logic [31:0] exp_maddr, input logic [31:0] exp_rdata,
                            input int rdy_dly, input int rsp_dly);
        lsu_issue(tag, addr, 1'b0, size, sext, 32'h0, 1'b0, exp_maddr, 4'b0000, 32'h0,
                  mrdata, exp_rdata, rdy_dly, rsp_dly);
    endtask

    task automatic lsu_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata, input logic [31:0] exp_maddr,
                             input logic [3:0] exp_wmask, input logic [31:0] exp_wdata);
        lsu_issue(tag, addr, 1'b1, size, 1'b0, wdata, 1'b0, exp_maddr, exp_wmask, exp_wdata,
                  32'hFFFF_FFFF, 32'h0, 0, 0);
    endtask

    task automatic lsu_bad(input string tag, input logic [31:0] addr, input logic wen,
                           input logic [1:0] size);
        lsu_issue(tag, addr, wen, size, 1'b1, 32'h1234_5678, 1'b1, 32'h0, 4'b0000, 32'h0,
                  32'h0, 32'h0, 0, 0);
    endtask

    task automatic ifu_issue(input string tag, input logic [31:0] addr, input logic [31:0] mrdata,
                             input logic [31:0] exp_maddr, input int rdy_dly, input int rsp_dly);
        resp_t r;
        mreq_t m;
        bit    ok = 1'b0;
        @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = addr;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.ifu_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check({tag, "_grant"}, bus.ifu_req_ready, 1'b1);
        end else begin
            grant_q.push_back(1'b0);
            r.lsu = 1'b0; r.tag = tag; r.err = 1'b0; r.rdata = mrdata;
            r.cyc = cyc + 3 + rdy_dly + rsp_dly;
            exp_q.push_back(r);
            m.addr = exp_maddr; m.wen = 1'b0; m.wmask = 4'b0000; m.chk_mask = 1'b0;
            m.wdata = 32'h0; m.rdata = mrdata; m.rdy_dly = rdy_dly;
            m.rsp_dly = rsp_dly; m.tag = tag;
            mem_q.push_back(m);
        end
        @(posedge clk);
        #1;
        bus.ifu_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || mem_q.size() != 0); i++) @(negedge clk);
        check("drain_resp_q", exp_q.size(), 0);
        check("drain_mem_q", mem_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem"}, {bus.mem_req_valid, bus.mem_wen, bus.mem_wmask, bus.mem_addr}, 64'h0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_resp"}, {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.lsu_err}, 3'b000);
        check({tag, "_rdata"}, {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
        check({tag, "_ready"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
    endtask

    initial begin
        bit exp_order[4];
        bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
        bus.lsu_size = 2'b00; bus.lsu_sext = 1'b0; bus.lsu_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        #1;
        check_reset_outputs("por");
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fetches: word pass-through, low address bits ignored.
        ifu_issue("fetch0", 32'h8000_0004, 32'h0050_0093, 32'h8000_0004, 0, 0);
        ifu_issue("fetch1", 32'h8000_0007, 32'h1234_5678, 32'h8000_0004, 1, 1);
        drain();

        // Stores: lane replication and byte enables.
        lsu_store("sb_off2", 32'h8000_0102, 2'b00, 32'h0000_00AB, 32'h8000_0100, 4'b0100, 32'hABAB_ABAB);
        lsu_store("sb_off1", 32'h8000_0011, 2'b00, 32'hFFFF_FF5A, 32'h8000_0010, 4'b0010, 32'h5A5A_5A5A);
        lsu_store("sh_off2", 32'h8000_0006, 2'b01, 32'h1234_BEEF, 32'h8000_0004, 4'b1100, 32'hBEEF_BEEF);
        lsu_store("sw_off0", 32'h8000_0008, 2'b10, 32'hCAFE_F00D, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D);
        drain();

        // Loads from 0x80F07FFF at various offsets and extensions.
        lsu_load("lh_o2_s", 32'h8000_0202, 2'b01, 1'b1, 32'h80F0_7FFF, 32'h8000_0200, 32'hFFFF_80F0, 0, 0);
        lsu_load("lh_o2_z", 32'h8000_0202, 2'b01, 1'b0, 32'h80F0_7FFF, 32'h8000_0200, 32'h0000_80F0, 0, 0);
        lsu_load("lb_o3_z", 32'h8000_0203, 2'b00, 1'b0, 32'h80F0_7FFF, 32'h8000_0200, 32'h0000_0080, 0, 0);
        lsu_load("lb_o3_s", 32'h8000_0203, 2'b00, 1'b1, 32'h80F0_7FFF, 32'h8000_0200, 32'hFFFF_FF80, 0, 0);
        lsu_load("lb_o0_s", 32'h8000_0200, 2'b00, 1'b1, 32'h80F0_7FFF, 32'h8000_0200, 32'hFFFF_FFFF, 0, 1);
        lsu_load("lb_o1_s", 32'h8000_0201, 2'b00, 1'b1, 32'h80F0_7FFF, 32'h8000_0200, 32'h0000_007F, 0, 0);
        lsu_load("lh_o0_s", 32'h8000_0200, 2'b01, 1'b1, 32'h80F0_7FFF, 32'h8000_0200, 32'h0000_7FFF, 0, 0);
        lsu_load("lw_o0", 32'h8000_0200, 2'b10, 1'b1, 32'h80F0_7FFF, 32'h8000_0200, 32'h80F0_7FFF, 2, 0);
        drain();

        // Misaligned and illegal-size requests: error, no memory access.
        lsu_bad("lw_mis1", 32'h8000_0001, 1'b0, 2'b10);
        lsu_bad("lw_mis2", 32'h8000_0002, 1'b0, 2'b10);
        lsu_bad("sh_mis3", 32'h8000_0003, 1'b1, 2'b01);
        lsu_bad("size11", 32'h8000_0000, 1'b0, 2'b11);
        drain();

        // Backpressure: five stall cycles while a fetch waits for grant.
        fork
            lsu_load("bp_lw", 32'h8000_0010, 2'b10, 1'b0, 32'h1122_3344, 32'h8000_0010, 32'h1122_3344, 5, 2);
            begin
                repeat (2) @(negedge clk);
                ifu_issue("bp_fetch", 32'h8000_0020, 32'h0000_0013, 32'h8000_0020, 0, 0);
            end
        join
        drain();

        // Reset while waiting for the memory response.
        mem_auto = 1'b0;
        @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0040;
        #1;
        check("rst_fetch_grant", bus.ifu_req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.ifu_req_valid = 1'b0;
        @(negedge clk);
        check("rst_fetch_req", {bus.mem_req_valid, bus.mem_addr}, {1'b1, 32'h8000_0040});
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0BAD_0BAD;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        repeat (4) @(negedge clk);
        mem_auto = 1'b1;

        // Both requesters contend from the first cycle.
        grant_q.delete();
        fork
            begin
                lsu_load("tie_l0", 32'h8000_0030, 2'b10, 1'b0, 32'hA000_0001, 32'h8000_0030, 32'hA000_0001, 0, 0);
                lsu_load("tie_l1", 32'h8000_0034, 2'b10, 1'b0, 32'hA000_0002, 32'h8000_0034, 32'hA000_0002, 0, 0);
                lsu_load("tie_l2", 32'h8000_0038, 2'b10, 1'b0, 32'hA000_0003, 32'h8000_0038, 32'hA000_0003, 0, 0);
            end
            ifu_issue("tie_f0", 32'h8000_1000, 32'h0000_0073, 32'h8000_1000, 0, 0);
        join
        drain();
`ifdef ARB_RR_EN
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
`else
        exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
`endif
        check("tie_grant_count", grant_q.size(), 4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++)
            check($sformatf("tie_grant_%0d_is_lsu", i), grant_q[i], exp_order[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
